// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and types for the polynomial-vector datapath.
package dilithium_pkg;

  localparam int unsigned K = 6;
  localparam int unsigned N = 256;
  localparam int unsigned W = 32;
  localparam int unsigned Q = 8380417;

  typedef logic signed [W-1:0] coeff_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/poly_lane_add.sv
// Combinational bank of LANES coefficient adders.
// Optional mod-Q reduction when POLYVECK_ADD_SEQ_REDUCE_EN is defined.
module poly_lane_add #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CW    = dilithium_pkg::W
) (
  input  logic [LANES*CW-1:0] i_u,
  input  logic [LANES*CW-1:0] i_v,
  output logic [LANES*CW-1:0] o_sum
);
  import dilithium_pkg::*;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [CW-1:0] w_u;
    logic [CW-1:0] w_v;
    assign w_u = i_u[gi*CW +: CW];
    assign w_v = i_v[gi*CW +: CW];
`ifdef POLYVECK_ADD_SEQ_REDUCE_EN
    localparam logic [CW:0] QW = (CW+1)'(Q);
    logic [CW:0] w_s;
    logic [CW:0] w_r;
    // Inputs lie in [0,Q), so a single conditional subtract suffices.
    assign w_s = {1'b0, w_u} + {1'b0, w_v};
    assign w_r = (w_s >= QW) ? (w_s - QW) : w_s;
    assign o_sum[gi*CW +: CW] = w_r[CW-1:0];
`else
    assign o_sum[gi*CW +: CW] = w_u + w_v;
`endif
  end

endmodule

// File: rtl/polyveck_add_seq.sv
// Time-multiplexed w = u + v sequencer streaming LANES coefficients per cycle.
// Build option POLYVECK_ADD_SEQ_REDUCE_EN enables mod-Q reduction in the lane adders.
module polyveck_add_seq #(
  parameter int unsigned K     = dilithium_pkg::K,
  parameter int unsigned N     = dilithium_pkg::N,
  parameter int unsigned W     = dilithium_pkg::W,
  parameter int unsigned LANES = 4,
  localparam int unsigned G    = K * N / LANES,
  localparam int unsigned AW   = $clog2(G)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic               hold_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               rd_en_out,
  output logic [AW-1:0]      rd_addr_out,
  input  logic [LANES*W-1:0] u_data_in,
  input  logic [LANES*W-1:0] v_data_in,
  output logic               wr_en_out,
  output logic [AW-1:0]      wr_addr_out,
  output logic [LANES*W-1:0] w_data_out
);
  import dilithium_pkg::*;

  localparam logic [AW-1:0] LastGrp = AW'(G - 1);

  seq_state_e         r_state, w_state_next;
  logic [AW-1:0]      r_rd_cnt, w_rd_cnt_next;
  logic [AW-1:0]      r_wr_cnt, w_wr_cnt_next;
  logic               w_issue;
  logic               r_valid_d;
  logic [AW-1:0]      r_addr_d;
  logic               r_wr_en;
  logic [AW-1:0]      r_wr_addr;
  logic [LANES*W-1:0] r_w_data;
  logic [LANES*W-1:0] w_sum;

  poly_lane_add #(
    .LANES (LANES),
    .CW    (W)
  ) u_lane_add (
    .i_u   (u_data_in),
    .i_v   (v_data_in),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_next  = r_state;
    w_rd_cnt_next = r_rd_cnt;
    w_wr_cnt_next = r_wr_en ? (r_wr_cnt + 1'b1) : r_wr_cnt;
    w_issue       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_in) begin
          w_state_next  = StIssue;
          w_rd_cnt_next = '0;
          w_wr_cnt_next = '0;
        end
      end
      StIssue: begin
        if (!hold_in) begin
          w_issue = 1'b1;
          if (r_rd_cnt == LastGrp) begin
            w_rd_cnt_next = '0;
            w_state_next  = StDrain;
          end else begin
            w_rd_cnt_next = r_rd_cnt + 1'b1;
          end
        end
      end
      StDrain: begin
        // Leave as the final write retires so done lands the cycle after it.
        if (r_wr_en && (r_wr_cnt == LastGrp)) begin
          w_wr_cnt_next = '0;
          w_state_next  = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= StIdle;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rd_cnt <= w_rd_cnt_next;
      r_wr_cnt <= w_wr_cnt_next;
    end
  end

  // Pipeline keeps flowing regardless of hold_in; only issue is gated.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid_d <= 1'b0;
      r_addr_d  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_w_data  <= '0;
    end else begin
      r_valid_d <= w_issue;
      if (w_issue) begin
        r_addr_d <= r_rd_cnt;
      end
      r_wr_en <= r_valid_d;
      if (r_valid_d) begin
        r_wr_addr <= r_addr_d;
        r_w_data  <= w_sum;
      end
    end
  end

  assign busy_out    = (r_state == StIssue) || (r_state == StDrain);
  assign done_out    = (r_state == StDone);
  assign rd_en_out   = w_issue;
  assign rd_addr_out = r_rd_cnt;
  assign wr_en_out   = r_wr_en;
  assign wr_addr_out = r_wr_addr;
  assign w_data_out  = r_w_data;

endmodule

// File: tb/tb_polyveck_add_seq.sv
// Directed bench for polyveck_add_seq with behavioural u/v RAMs and a write scoreboard.
module tb_polyveck_add_seq;
  localparam int unsigned K     = 6;
  localparam int unsigned N     = 256;
  localparam int unsigned W     = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned G     = K * N / LANES;
  localparam int unsigned AW    = $clog2(G);
  localparam int unsigned Q     = 8380417;

  typedef struct {
    int         g;
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic [W-1:0] e;
  } vec_t;

  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic               start_in = 1'b0;
  logic               hold_in = 1'b0;
  logic               busy_out, done_out, rd_en_out, wr_en_out;
  logic [AW-1:0]      rd_addr_out, wr_addr_out;
  logic [LANES*W-1:0] u_data_in = '0;
  logic [LANES*W-1:0] v_data_in = '0;
  logic [LANES*W-1:0] w_data_out;

  always #5 clk_in = ~clk_in;

  polyveck_add_seq #(
    .K     (K),
    .N     (N),
    .W     (W),
    .LANES (LANES)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .start_in    (start_in),
    .hold_in     (hold_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .rd_en_out   (rd_en_out),
    .rd_addr_out (rd_addr_out),
    .u_data_in   (u_data_in),
    .v_data_in   (v_data_in),
    .wr_en_out   (wr_en_out),
    .wr_addr_out (wr_addr_out),
    .w_data_out  (w_data_out)
  );

  logic [LANES*W-1:0] u_mem [G];
  logic [LANES*W-1:0] v_mem [G];
  logic [LANES*W-1:0] w_got [G];
  vec_t               vecs  [4];

  always @(posedge clk_in) begin
    if (rd_en_out) begin
      u_data_in <= u_mem[rd_addr_out];
      v_data_in <= v_mem[rd_addr_out];
    end
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int t0 = 0;
  int n_rd, first_rd, last_rd, rd_in_hold;
  int n_wr, first_wr, wr_addr_err;
  int n_done, done_cyc;
  int n_busy, busy_first, busy_last;
  int n_checks = 0;
  int n_errs = 0;

  always @(negedge clk_in) begin
    int rel;
    rel = cyc - t0;
    if (rd_en_out) begin
      n_rd++;
      if (first_rd < 0) first_rd = rel;
      last_rd = rel;
      if (rel >= 10 && rel <= 14) rd_in_hold++;
    end
    if (wr_en_out) begin
      if (first_wr < 0) first_wr = rel;
      if (wr_addr_out != AW'(n_wr)) wr_addr_err++;
      if (int'(wr_addr_out) < G) w_got[wr_addr_out] = w_data_out;
      n_wr++;
    end
    if (done_out) begin
      n_done++;
      done_cyc = rel;
    end
    if (busy_out) begin
      n_busy++;
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef POLYVECK_ADD_SEQ_REDUCE_EN
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
    return s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  task automatic clear_stats();
    n_rd = 0; first_rd = -1; last_rd = -1; rd_in_hold = 0;
    n_wr = 0; first_wr = -1; wr_addr_err = 0;
    n_done = 0; done_cyc = -1;
    n_busy = 0; busy_first = -1; busy_last = -1;
    for (int g = 0; g < G; g++) w_got[g] = {LANES{32'hDEADBEEF}};
  endtask

  // Starts a run in the current cycle (cycle 0) and returns in the cycle after done.
  task automatic run(input int hold_lo, input int hold_hi, input int start_again,
                     output int timed_out);
    t0 = cyc;
    clear_stats();
    start_in  = 1'b1;
    timed_out = 1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk_in); #1;
      start_in = ((cyc - t0) == start_again);
      hold_in  = ((cyc - t0) >= hold_lo) && ((cyc - t0) <= hold_hi);
      if (n_done > 0 && (cyc - t0) == done_cyc + 1) begin
        timed_out = 0;
        break;
      end
    end
    start_in = 1'b0;
    hold_in  = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_done, input int exp_rd_last,
                           input int timed_out);
    int derr;
    derr = 0;
    for (int g = 0; g < G; g++)
      for (int i = 0; i < LANES; i++)
        if (w_got[g][i*W +: W] != model_add(u_mem[g][i*W +: W], v_mem[g][i*W +: W])) derr++;
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_n_rd"}, n_rd, G);
    chk({tag, "_first_rd"}, first_rd, 1);
    chk({tag, "_last_rd"}, last_rd, exp_rd_last);
    chk({tag, "_first_wr"}, first_wr, 3);
    chk({tag, "_n_wr"}, n_wr, G);
    chk({tag, "_wr_addr_order"}, wr_addr_err, 0);
    chk({tag, "_data_errs"}, derr, 0);
    chk({tag, "_n_done"}, n_done, 1);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_busy_first"}, busy_first, 1);
    chk({tag, "_busy_last"}, busy_last, exp_done - 1);
    chk({tag, "_busy_cycles"}, n_busy, exp_done - 1);
  endtask

  initial begin
    int to;
    for (int g = 0; g < G; g++)
      for (int i = 0; i < LANES; i++) begin
        u_mem[g][i*W +: W] = W'(g * 4 + i);
        v_mem[g][i*W +: W] = W'(1000);
      end
`ifdef POLYVECK_ADD_SEQ_REDUCE_EN
    vecs[0] = '{g: 5,   u: 32'd8380416, v: 32'd5,       e: 32'd4};
    vecs[1] = '{g: 17,  u: 32'd3,       v: 32'd4,       e: 32'd7};
    vecs[2] = '{g: 100, u: 32'd8380416, v: 32'd1,       e: 32'd0};
    vecs[3] = '{g: 383, u: 32'd4190208, v: 32'd4190208, e: 32'd8380416};
`else
    vecs[0] = '{g: 5,   u: 32'h7FFFFFFF, v: 32'h00000001, e: 32'h80000000};
    vecs[1] = '{g: 17,  u: 32'hFFFFFFFF, v: 32'h00000001, e: 32'h00000000};
    vecs[2] = '{g: 100, u: 32'h80000000, v: 32'h80000000, e: 32'h00000000};
    vecs[3] = '{g: 383, u: 32'h12345678, v: 32'h11111111, e: 32'h23456789};
`endif
    foreach (vecs[j]) begin
      u_mem[vecs[j].g] = {LANES{vecs[j].u}};
      v_mem[vecs[j].g] = {LANES{vecs[j].v}};
    end
    clear_stats();

    // Reset state
    #12;
    chk("reset_ctrl", {busy_out, done_out, rd_en_out, wr_en_out}, 0);
    chk("reset_addr", {rd_addr_out, wr_addr_out}, 0);
    chk("reset_data", (w_data_out != '0), 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("idle_busy", busy_out, 0);

    // Basic run plus directed lane vectors
    run(1000, -1, -1, to);
    check_run("basic", 387, 384, to);
    foreach (vecs[j])
      for (int i = 0; i < LANES; i++)
        chk($sformatf("vec%0d_lane%0d", j, i), w_got[vecs[j].g][i*W +: W], vecs[j].e);

    // Back-to-back: second start in the cycle right after done
    run(1000, -1, -1, to);
    check_run("b2b", 387, 384, to);

    // Hold bubbles in cycles 10..14
    run(10, 14, -1, to);
    check_run("hold", 392, 389, to);
    chk("hold_rd_in_window", rd_in_hold, 0);

    // Start pulse while busy is ignored
    run(1000, -1, 100, to);
    check_run("restart", 387, 384, to);
    repeat (10) @(posedge clk_in);
    #1;
    chk("restart_no_second_rd", n_rd, G);
    chk("restart_no_second_done", n_done, 1);

    // Reset mid-run
    t0 = cyc;
    clear_stats();
    start_in = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_in); #1;
      start_in = 1'b0;
    end
    chk("midrst_busy_before", busy_out, 1);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_ctrl", {busy_out, done_out, rd_en_out, wr_en_out}, 0);
    chk("midrst_addr", {rd_addr_out, wr_addr_out}, 0);
    chk("midrst_data", (w_data_out != '0), 0);
    repeat (5) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    chk("midrst_no_done", n_done, 0);
    chk("midrst_idle", busy_out, 0);
    run(1000, -1, -1, to);
    check_run("after_rst", 387, 384, to);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
